// File: rtl/agree_predictor_v3.sv
// Agree branch predictor: WAYS-way BTB with per-entry bias, gshare-indexed agree counters and a GHR.
// Optional speculative GHR with mispredict recovery when AGREE_GHR_RECOVER_EN is defined.
module agree_predictor_v3 #(
  parameter int unsigned INDEX_WIDTH   = 6,
  parameter int unsigned HISTORY_WIDTH = 8,
  parameter int unsigned WAYS          = 2,
  parameter int unsigned CTR_WIDTH     = 2,
  localparam int unsigned WayW         = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     IF_valid_i,
  input  logic [31:0]              IF_pc_i,
  output logic                     IF_btb_hit_o,
  output logic                     IF_prediction_o,
  output logic                     IF_bias_o,
  output logic [31:0]              IF_btb_rd_target_o,
  output logic [WayW-1:0]          IF_way_o,
  output logic [HISTORY_WIDTH-1:0] IF_ghr_data_o,
  input  logic                     EXMEM_valid_i,
  input  logic [31:0]              EXMEM_pc_i,
  input  logic [31:0]              EXMEM_target_i,
  input  logic                     EXMEM_is_br_i,
  input  logic                     EXMEM_is_jmp_i,
  input  logic                     EXMEM_br_decision_i,
  input  logic                     EXMEM_btb_hit_i,
  input  logic [WayW-1:0]          EXMEM_way_i,
  input  logic                     EXMEM_prediction_i,
  input  logic                     EXMEM_bias_i,
  input  logic [HISTORY_WIDTH-1:0] EXMEM_ghr_data_i,
  output logic                     EXMEM_mispredict_o
);

  localparam int Sets    = 2 ** INDEX_WIDTH;
  localparam int TagW    = 30 - INDEX_WIDTH;
  localparam int PhtSize = 2 ** HISTORY_WIDTH;
  localparam logic [CTR_WIDTH-1:0] CtrInit = CTR_WIDTH'(1) << (CTR_WIDTH - 1);
  localparam logic [CTR_WIDTH-1:0] CtrMax  = '1;

  logic                 valid_q  [Sets][WAYS];
  logic [TagW-1:0]      tag_q    [Sets][WAYS];
  logic [31:0]          target_q [Sets][WAYS];
  logic                 bias_q   [Sets][WAYS];
  logic                 cond_q   [Sets][WAYS];
  logic [WayW-1:0]      rr_q     [Sets];
  logic [CTR_WIDTH-1:0] pht_q    [PhtSize];
  logic [HISTORY_WIDTH-1:0] ghr_q, ghr_d;

  // Fetch-side lookup
  logic [INDEX_WIDTH-1:0]   if_set;
  logic [TagW-1:0]          if_tag;
  logic [HISTORY_WIDTH-1:0] if_pht_idx;
  logic [CTR_WIDTH-1:0]     if_ctr;
  logic                     hit;
  logic [WayW-1:0]          way;
  logic                     hit_bias, hit_cond;

  assign if_set     = IF_pc_i[INDEX_WIDTH+1:2];
  assign if_tag     = IF_pc_i[31:INDEX_WIDTH+2];
  assign if_pht_idx = IF_pc_i[HISTORY_WIDTH+1:2] ^ ghr_q;
  assign if_ctr     = pht_q[if_pht_idx];

  // Descending scan so the lowest-numbered matching way wins.
  always_comb begin
    hit = 1'b0;
    way = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (valid_q[if_set][w] && (tag_q[if_set][w] == if_tag)) begin
        hit = 1'b1;
        way = WayW'(w);
      end
    end
  end

  assign hit_bias = bias_q[if_set][way];
  assign hit_cond = cond_q[if_set][way];

  assign IF_btb_hit_o       = hit;
  assign IF_bias_o          = hit & hit_bias;
  assign IF_prediction_o    = hit & (hit_cond ? (if_ctr[CTR_WIDTH-1] ~^ hit_bias) : 1'b1);
  assign IF_btb_rd_target_o = hit ? target_q[if_set][way] : 32'h0;
  assign IF_way_o           = way;
  assign IF_ghr_data_o      = ghr_q;

  // Commit-side training
  logic                     cm_active, cm_cond, cm_taken;
  logic [INDEX_WIDTH-1:0]   cm_set;
  logic [TagW-1:0]          cm_tag;
  logic [HISTORY_WIDTH-1:0] cm_pht_idx;
  logic [CTR_WIDTH-1:0]     cm_ctr, ctr_next;
  logic                     cm_agree;
  logic [WayW-1:0]          victim;
  logic                     use_rr;
  logic                     alloc, retarget, pht_upd;

  // Both is_br and is_jmp high behaves as a jump.
  assign cm_active  = EXMEM_valid_i & (EXMEM_is_br_i | EXMEM_is_jmp_i);
  assign cm_cond    = EXMEM_is_br_i & ~EXMEM_is_jmp_i;
  assign cm_taken   = cm_cond ? EXMEM_br_decision_i : 1'b1;
  assign cm_set     = EXMEM_pc_i[INDEX_WIDTH+1:2];
  assign cm_tag     = EXMEM_pc_i[31:INDEX_WIDTH+2];
  assign cm_pht_idx = EXMEM_pc_i[HISTORY_WIDTH+1:2] ^ EXMEM_ghr_data_i;
  assign cm_ctr     = pht_q[cm_pht_idx];
  assign cm_agree   = EXMEM_br_decision_i ~^ EXMEM_bias_i;

  assign alloc    = cm_active & ~EXMEM_btb_hit_i;
  assign retarget = cm_active & EXMEM_btb_hit_i & cm_taken;
  assign pht_upd  = cm_active & EXMEM_btb_hit_i & cm_cond;

  assign EXMEM_mispredict_o = cm_active & (EXMEM_prediction_i ^ EXMEM_br_decision_i);

  always_comb begin
    victim = rr_q[cm_set];
    use_rr = 1'b1;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_q[cm_set][w]) begin
        victim = WayW'(w);
        use_rr = 1'b0;
      end
    end
  end

  always_comb begin
    ctr_next = cm_ctr;
    if (cm_agree) begin
      if (cm_ctr != CtrMax) ctr_next = cm_ctr + CTR_WIDTH'(1);
    end else begin
      if (cm_ctr != '0) ctr_next = cm_ctr - CTR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < Sets; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < int'(WAYS); w++) begin
          valid_q[s][w]  <= 1'b0;
          tag_q[s][w]    <= '0;
          target_q[s][w] <= '0;
          bias_q[s][w]   <= 1'b0;
          cond_q[s][w]   <= 1'b0;
        end
      end
    end else begin
      if (alloc) begin
        valid_q[cm_set][victim]  <= 1'b1;
        tag_q[cm_set][victim]    <= cm_tag;
        target_q[cm_set][victim] <= EXMEM_target_i;
        bias_q[cm_set][victim]   <= cm_taken;
        cond_q[cm_set][victim]   <= cm_cond;
        if (use_rr && (WAYS > 1)) rr_q[cm_set] <= rr_q[cm_set] + WayW'(1);
      end
      if (retarget) target_q[cm_set][EXMEM_way_i] <= EXMEM_target_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < PhtSize; i++) pht_q[i] <= CtrInit;
    end else if (pht_upd) begin
      pht_q[cm_pht_idx] <= ctr_next;
    end
  end

`ifdef AGREE_GHR_RECOVER_EN
  // A mispredicted commit restores history and overrides the fetch-side shift.
  always_comb begin
    ghr_d = ghr_q;
    if (cm_active && cm_cond && (EXMEM_prediction_i ^ EXMEM_br_decision_i)) begin
      ghr_d = {EXMEM_ghr_data_i[HISTORY_WIDTH-2:0], EXMEM_br_decision_i};
    end else if (IF_valid_i && hit && hit_cond) begin
      ghr_d = {ghr_q[HISTORY_WIDTH-2:0], IF_prediction_o};
    end
  end
`else
  logic unused_if_valid;
  assign unused_if_valid = IF_valid_i;

  always_comb begin
    ghr_d = ghr_q;
    if (cm_active && cm_cond) ghr_d = {ghr_q[HISTORY_WIDTH-2:0], EXMEM_br_decision_i};
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{IF_pc_i[1:0], EXMEM_pc_i[1:0]};

endmodule

// File: tb/tb_agree_predictor_v3.sv
// Directed self-checking bench for agree_predictor_v3 (default parameters).
module tb_agree_predictor_v3;

  logic        clk, rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        if_hit, if_pred, if_bias;
  logic [31:0] if_target;
  logic [0:0]  if_way;
  logic [7:0]  if_ghr;
  logic        ex_valid, ex_is_br, ex_is_jmp, ex_dec, ex_hit, ex_pred, ex_bias;
  logic [31:0] ex_pc, ex_target;
  logic [0:0]  ex_way;
  logic [7:0]  ex_ghr;
  logic        ex_mispredict;

  int checks = 0;
  int failures = 0;

  agree_predictor_v3 dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .IF_valid_i          (if_valid),
    .IF_pc_i             (if_pc),
    .IF_btb_hit_o        (if_hit),
    .IF_prediction_o     (if_pred),
    .IF_bias_o           (if_bias),
    .IF_btb_rd_target_o  (if_target),
    .IF_way_o            (if_way),
    .IF_ghr_data_o       (if_ghr),
    .EXMEM_valid_i       (ex_valid),
    .EXMEM_pc_i          (ex_pc),
    .EXMEM_target_i      (ex_target),
    .EXMEM_is_br_i       (ex_is_br),
    .EXMEM_is_jmp_i      (ex_is_jmp),
    .EXMEM_br_decision_i (ex_dec),
    .EXMEM_btb_hit_i     (ex_hit),
    .EXMEM_way_i         (ex_way),
    .EXMEM_prediction_i  (ex_pred),
    .EXMEM_bias_i        (ex_bias),
    .EXMEM_ghr_data_i    (ex_ghr),
    .EXMEM_mispredict_o  (ex_mispredict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ex_valid  = 1'b0;
    ex_pc     = 32'h0;
    ex_target = 32'h0;
    ex_is_br  = 1'b0;
    ex_is_jmp = 1'b0;
    ex_dec    = 1'b0;
    ex_hit    = 1'b0;
    ex_way    = 1'b0;
    ex_pred   = 1'b0;
    ex_bias   = 1'b0;
    ex_ghr    = 8'h0;
  endtask

  task automatic commit(input logic [31:0] pc, input logic [31:0] tgt, input logic br,
                        input logic jmp, input logic dec, input logic hit, input logic w,
                        input logic pred, input logic bias, input logic [7:0] ghr);
    ex_valid  = 1'b1;
    ex_pc     = pc;
    ex_target = tgt;
    ex_is_br  = br;
    ex_is_jmp = jmp;
    ex_dec    = dec;
    ex_hit    = hit;
    ex_way    = w;
    ex_pred   = pred;
    ex_bias   = bias;
    ex_ghr    = ghr;
  endtask

  task automatic lookup(input logic [31:0] pc);
    @(negedge clk);
    idle();
    if_pc = pc;
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    if_valid = 1'b0;
    if_pc    = 32'h100;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_hit", if_hit, 0);
    check("rst_pred", if_pred, 0);
    check("rst_bias", if_bias, 0);
    check("rst_target", if_target, 0);
    check("rst_ghr", if_ghr, 0);
    check("rst_mispredict", ex_mispredict, 0);

    // Taken conditional miss allocates; same-cycle read still sees the old contents.
    @(negedge clk);
    commit(32'h100, 32'h200, 1, 0, 1, 0, 0, 0, 0, 8'h00);
    #1;
    check("alloc_mispredict", ex_mispredict, 1);
    check("alloc_no_bypass", if_hit, 0);
    lookup(32'h100);
    check("alloc_hit", if_hit, 1);
    check("alloc_bias", if_bias, 1);
    check("alloc_target", if_target, 32'h200);
    check("alloc_pred", if_pred, 1);
    check("alloc_ghr", if_ghr, 8'h01);
    check("alloc_way", if_way, 0);

    // Set 1 via jumps: fill both ways, then round-robin replaces way 0, then way 1.
    @(negedge clk); commit(32'h004, 32'h1004, 0, 1, 1, 0, 0, 0, 0, 8'h00);
    @(negedge clk); commit(32'h104, 32'h1104, 0, 1, 1, 0, 0, 0, 0, 8'h00);
    @(negedge clk); commit(32'h204, 32'h1204, 0, 1, 1, 0, 0, 0, 0, 8'h00);
    lookup(32'h004);
    check("rr_evicted_hit", if_hit, 0);
    lookup(32'h104);
    check("rr_w1_hit", if_hit, 1);
    check("rr_w1_way", if_way, 1);
    check("rr_w1_target", if_target, 32'h1104);
    check("rr_w1_pred", if_pred, 1);
    lookup(32'h204);
    check("rr_w0_way", if_way, 0);
    check("rr_w0_target", if_target, 32'h1204);
    @(negedge clk); commit(32'h304, 32'h1304, 0, 1, 1, 0, 0, 0, 0, 8'h00);
    lookup(32'h104);
    check("rr2_evicted_hit", if_hit, 0);
    lookup(32'h304);
    check("rr2_way", if_way, 1);
    check("rr2_target", if_target, 32'h1304);
    lookup(32'h204);
    check("rr2_keep_hit", if_hit, 1);

    // JAL miss allocation: predicted taken, bias 1, history untouched.
    @(negedge clk); commit(32'h040, 32'h080, 0, 1, 1, 0, 0, 0, 0, 8'h00);
    lookup(32'h040);
    check("jal_hit", if_hit, 1);
    check("jal_pred", if_pred, 1);
    check("jal_bias", if_bias, 1);
    check("jal_target", if_target, 32'h080);
    check("jal_ghr", if_ghr, 8'h01);

`ifndef AGREE_GHR_RECOVER_EN
    // Counter at index 0x40^0x11: 2 -> 1 -> 0 -> 0 -> 1; not-taken commits keep the target.
    @(negedge clk); commit(32'h100, 32'h999, 1, 0, 0, 1, 0, 1, 1, 8'h11);
    #1;
    check("nt_mispredict", ex_mispredict, 1);
    @(negedge clk); commit(32'h100, 32'h999, 1, 0, 0, 1, 0, 1, 1, 8'h11);
    @(negedge clk); commit(32'h100, 32'h999, 1, 0, 0, 1, 0, 1, 1, 8'h11);
    lookup(32'h100);
    check("nt_target_kept", if_target, 32'h200);
    check("nt_ghr", if_ghr, 8'h08);
    @(negedge clk); commit(32'h100, 32'h300, 1, 0, 1, 1, 0, 0, 1, 8'h11);
    lookup(32'h100);
    check("sat_hit", if_hit, 1);
    check("sat_bias", if_bias, 1);
    check("sat_target", if_target, 32'h300);
    check("sat_ghr", if_ghr, 8'h11);
    check("sat_pred", if_pred, 0);

    // Hit JAL commits aimed at the same counter must leave it and the GHR alone.
    @(negedge clk); commit(32'h040, 32'h080, 0, 1, 1, 1, 0, 1, 1, 8'h41);
    #1;
    check("jal_hit_mispredict", ex_mispredict, 0);
    @(negedge clk); commit(32'h040, 32'h080, 1, 1, 1, 1, 0, 1, 1, 8'h41);
    lookup(32'h100);
    check("jal_pht_pred", if_pred, 0);
    check("jal_pht_ghr", if_ghr, 8'h11);
`else
    // Speculative shift, then a mispredict restore wins over the same-cycle shift.
    @(negedge clk);
    idle();
    if_valid = 1'b1;
    if_pc    = 32'h100;
    #1;
    check("spec_ghr0", if_ghr, 8'h01);
    check("spec_pred0", if_pred, 1);
    @(negedge clk);
    commit(32'h100, 32'h200, 1, 0, 0, 1, 0, 1, 1, 8'h00);
    #1;
    check("spec_ghr1", if_ghr, 8'h03);
    check("spec_mispredict", ex_mispredict, 1);
    @(negedge clk);
    idle();
    if_valid = 1'b0;
    #1;
    check("recover_ghr", if_ghr, 8'h00);
    check("recover_pred", if_pred, 0);
`endif

    // Asynchronous reset mid-cycle discards the pending allocation.
    @(negedge clk);
    commit(32'h500, 32'h600, 1, 0, 1, 0, 0, 0, 0, 8'h00);
    if_pc = 32'h100;
    #1;
    check("pre_rst_hit", if_hit, 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_hit", if_hit, 0);
    check("async_rst_ghr", if_ghr, 0);
    check("async_rst_target", if_target, 0);
    @(negedge clk);
    idle();
    rst = 1'b0;
    lookup(32'h500);
    check("rst_discard_hit", if_hit, 0);
    check("rst_discard_pred", if_pred, 0);
    check("rst_discard_mispredict", ex_mispredict, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
